// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between the requesters/FIFO flag (master side) and the
// round-robin FIFO write arbiter (slave side).
interface fifo_write_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]            req;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_last;
    logic                       full;
    logic                       w_en;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [NREQ-1:0]            gnt;
    logic [OW-1:0]              owner;
    logic                       busy;

    modport master (
        output req, req_data, req_last, full,
        input  w_en, wdata, gnt, owner, busy
    );

    modport slave (
        input  req, req_data, req_last, full,
        output w_en, wdata, gnt, owner, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// Define WARB_BURST_LIMIT_EN to end each grant after MAX_BURST accepted beats.
module fifo_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    fifo_write_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    if (NREQ < 2 || NREQ > 8) begin : gBadNreq
        $error("fifo_write_arbiter: NREQ must be in 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : gBadBurst
        $error("fifo_write_arbiter: MAX_BURST must be in 1..255");
    end

    state_t                state_q;
    logic [OW-1:0]         owner_q;
    logic [OW-1:0]         lastServed_q;
    logic [7:0]            beatCount_q;
    logic                  busy_q;

    logic [OW-1:0]         winner;
    logic                  anyReq;
    logic                  ownerReq;
    logic                  ownerLast;
    logic [DATA_WIDTH-1:0] ownerData;
    logic                  accept;
    logic                  limitHit;
    logic                  burstEnd;

    // Rotating priority: the requester just after the last-served one wins.
    always_comb begin
        logic          found;
        logic [OW-1:0] cand;
        winner = lastServed_q;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = OW'((int'(lastServed_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign anyReq = |bus.req;

    always_comb begin
        ownerReq  = 1'b0;
        ownerLast = 1'b0;
        ownerData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                ownerReq  = bus.req[i];
                ownerLast = bus.req_last[i];
                ownerData = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = busy_q & ownerReq & ~bus.full;

`ifdef WARB_BURST_LIMIT_EN
    assign limitHit = ((beatCount_q + 8'd1) == 8'(MAX_BURST));
`else
    assign limitHit = 1'b0;
`endif

    // A withdrawn request ends the grant even while the FIFO is full.
    assign burstEnd = busy_q & (~ownerReq | (accept & (ownerLast | limitHit)));

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            lastServed_q <= OW'(NREQ - 1);
            beatCount_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        state_q     <= BURST;
                        busy_q      <= 1'b1;
                        owner_q     <= winner;
                        beatCount_q <= '0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beatCount_q <= beatCount_q + 8'd1;
                    end
                    if (burstEnd) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        lastServed_q <= owner_q;
                    end
                end
            endcase
        end
    end

    assign bus.w_en  = accept;
    assign bus.gnt   = accept ? (NREQ'(1) << owner_q) : '0;
    assign bus.wdata = busy_q ? ownerData : '0;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
endmodule
